// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: merges ALU and load results into the reg_file write port and tracks pending writes.
// Defining WB_FORWARD_EN adds combinational forwarding of the in-flight write to two read ports.
module reg_writeback_unit #(
    parameter int LSU_FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
`ifdef WB_FORWARD_EN
    input  logic [4:0]  fwd_addr_rs1,
    input  logic [4:0]  fwd_addr_rs2,
    output logic        fwd_hit_rs1,
    output logic        fwd_hit_rs2,
    output logic [31:0] fwd_data_rs1,
    output logic [31:0] fwd_data_rs2,
`endif
    output logic [5:0]  write_params,
    output logic [31:0] data_rd,
    output logic [31:0] busy_bits
);
    localparam int PW = $clog2(LSU_FIFO_DEPTH);
    localparam logic [PW:0] CNT_FULL = LSU_FIFO_DEPTH[PW:0];
    localparam logic [PW:0] CNT_ONE = 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [36:0]   fifo_q [LSU_FIFO_DEPTH];
    logic          we_q, we_d;
    logic [4:0]    addr_q, addr_d;
    logic [31:0]   data_q, data_d, busy_q, busy_d;
    logic          alu_win, push, pop;

    always_comb begin
        lsu_ready = count_q != CNT_FULL;
        alu_win   = alu_valid && alu_rd != 5'd0;
        pop       = !alu_win && count_q != '0;
        // x0 loads still handshake but are never stored
        push      = lsu_valid && lsu_ready && lsu_rd != 5'd0;
        wr_ptr_d  = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d   = (push && !pop) ? count_q + CNT_ONE :
                    (pop && !push) ? count_q - CNT_ONE : count_q;
        we_d      = alu_win || pop;
        addr_d    = alu_win ? alu_rd : pop ? fifo_q[rd_ptr_q][36:32] : addr_q;
        data_d    = alu_win ? alu_data : pop ? fifo_q[rd_ptr_q][31:0] : data_q;
        // a same-edge issue re-marks the register after the commit clears it
        busy_d    = ((busy_q & ~(we_q ? 32'd1 << addr_q : 32'd0)) |
                     (issue_valid ? 32'd1 << issue_rd : 32'd0)) & 32'hFFFF_FFFE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_q[wr_ptr_q] <= {lsu_rd, lsu_data};
    end

    assign write_params = {addr_q, we_q};
    assign data_rd      = data_q;
    assign busy_bits    = busy_q;

`ifdef WB_FORWARD_EN
    assign fwd_hit_rs1  = we_q && addr_q == fwd_addr_rs1 && addr_q != 5'd0;
    assign fwd_hit_rs2  = we_q && addr_q == fwd_addr_rs2 && addr_q != 5'd0;
    assign fwd_data_rs1 = data_q;
    assign fwd_data_rs2 = data_q;
`endif
endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb_reg_writeback_unit: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_reg_writeback_unit;
    localparam int DEPTH = 4;

    logic        clock = 1'b0, reset = 1'b1;
    logic        alu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
    logic [4:0]  alu_rd = '0, lsu_rd = '0, issue_rd = '0;
    logic [31:0] alu_data = '0, lsu_data = '0;
    logic        lsu_ready;
    logic [5:0]  write_params;
    logic [31:0] data_rd, busy_bits;
`ifdef WB_FORWARD_EN
    logic [4:0]  fwd_addr_rs1 = '0, fwd_addr_rs2 = '0;
    logic        fwd_hit_rs1, fwd_hit_rs2;
    logic [31:0] fwd_data_rs1, fwd_data_rs2;
`endif

    int vectors = 0, miscompares = 0;

    logic [36:0] q[$];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data, m_busy;

    reg_writeback_unit #(.LSU_FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
`ifdef WB_FORWARD_EN
        .fwd_addr_rs1(fwd_addr_rs1), .fwd_addr_rs2(fwd_addr_rs2),
        .fwd_hit_rs1(fwd_hit_rs1), .fwd_hit_rs2(fwd_hit_rs2),
        .fwd_data_rs1(fwd_data_rs1), .fwd_data_rs2(fwd_data_rs2),
`endif
        .write_params(write_params), .data_rd(data_rd), .busy_bits(busy_bits)
    );

    always #5 clock = ~clock;

    task automatic idle_inputs();
        alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
        alu_rd = '0; lsu_rd = '0; issue_rd = '0; alu_data = '0; lsu_data = '0;
    endtask

    task automatic clear_model();
        q.delete();
        m_we = 1'b0; m_addr = '0; m_data = '0; m_busy = '0;
    endtask

    // advance one clock edge, updating the reference model from the inputs seen at that edge
    task automatic step();
        logic        n_we;
        logic [4:0]  n_addr;
        logic [31:0] n_data, n_busy;
        logic [36:0] e;
        bit          room;
        room   = q.size() < DEPTH;
        n_busy = m_busy;
        if (m_we) n_busy[m_addr] = 1'b0;
        if (issue_valid) n_busy[issue_rd] = 1'b1;
        n_busy[0] = 1'b0;
        n_we = 1'b0; n_addr = m_addr; n_data = m_data;
        if (alu_valid && alu_rd != 0) begin
            n_we = 1'b1; n_addr = alu_rd; n_data = alu_data;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            n_we = 1'b1; n_addr = e[36:32]; n_data = e[31:0];
        end
        if (lsu_valid && room && lsu_rd != 0) q.push_back({lsu_rd, lsu_data});
        @(posedge clock); #1;
        m_we = n_we; m_addr = n_addr; m_data = n_data; m_busy = n_busy;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        #1 clear_model();
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        repeat (2) @(posedge clock);
        #1 clear_model();
        vectors++;
        if (write_params !== 6'd0 || data_rd !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_out: write_params=%h data_rd=%h required 00/00000000", write_params, data_rd);
        end
        vectors++;
        if (busy_bits !== 32'd0 || lsu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: busy=%h ready=%b required 0/1", busy_bits, lsu_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_alu_write();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        idle_inputs();
`ifdef WB_FORWARD_EN
        fwd_addr_rs1 = 5'd5; fwd_addr_rs2 = 5'd6;
        #1;
        vectors++;
        if (fwd_hit_rs1 !== 1'b1 || fwd_data_rs1 !== 32'hDEADBEEF || fwd_hit_rs2 !== 1'b0) begin
            miscompares++;
            $display("FAIL fwd_hit: hit1=%b data1=%h hit2=%b required 1/deadbeef/0", fwd_hit_rs1, fwd_data_rs1, fwd_hit_rs2);
        end
`endif
        vectors++;
        if (write_params !== {5'd5, 1'b1} || data_rd !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL alu_write: write_params=%h data_rd=%h required 0b/deadbeef", write_params, data_rd);
        end
        step();
        vectors++;
        if (write_params[0] !== 1'b0 || write_params[5:1] !== 5'd5 || data_rd !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL alu_hold: write_params=%h data_rd=%h required 0a/deadbeef", write_params, data_rd);
        end
    endtask

    task automatic test_alu_lsu_priority();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h11;
        step();
        idle_inputs();
        vectors++;
        if (write_params !== {5'd3, 1'b1} || data_rd !== 32'h33) begin
            miscompares++;
            $display("FAIL prio_alu: write_params=%h data_rd=%h required 07/00000033", write_params, data_rd);
        end
        step();
        vectors++;
        if (write_params !== {5'd4, 1'b1} || data_rd !== 32'h11) begin
            miscompares++;
            $display("FAIL prio_lsu: write_params=%h data_rd=%h required 09/00000011", write_params, data_rd);
        end
        step();
    endtask

    task automatic test_fifo_full_drain();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd1; alu_data = i;
            lsu_valid = 1'b1; lsu_rd = 5'(10 + i); lsu_data = 32'hA000_0000 + i;
            step();
        end
        idle_inputs();
        vectors++;
        if (lsu_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fifo_full: lsu_ready=%b required 0", lsu_ready);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (write_params !== {5'(10 + i), 1'b1} || data_rd !== 32'hA000_0000 + i) begin
                miscompares++;
                $display("FAIL drain_%0d: write_params=%h data_rd=%h required %h/%h", i, write_params, data_rd,
                         {5'(10 + i), 1'b1}, 32'hA000_0000 + i);
            end
            if (i == 0) begin
                vectors++;
                if (lsu_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ready_after_pop: lsu_ready=%b required 1", lsu_ready);
                end
            end
        end
        step();
    endtask

    task automatic test_busy_set_wins();
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        idle_inputs();
        vectors++;
        if (busy_bits[7] !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_set: busy=%h required bit7=1", busy_bits);
        end
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        step();
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        idle_inputs();
        vectors++;
        if (busy_bits[7] !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_set_wins: busy=%h required bit7=1", busy_bits);
        end
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78;
        step();
        idle_inputs();
        step();
        vectors++;
        if (busy_bits[7] !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_clear: busy=%h required bit7=0", busy_bits);
        end
    endtask

    task automatic test_rd_zero();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        issue_valid = 1'b1; issue_rd = 5'd0;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h5678;
        step();
        idle_inputs();
        vectors++;
        if (write_params[0] !== 1'b0 || busy_bits !== 32'd0 || lsu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_zero: we=%b busy=%h ready=%b required 0/0/1", write_params[0], busy_bits, lsu_ready);
        end
        step();
        vectors++;
        if (write_params[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_zero_lsu: we=%b required 0", write_params[0]);
        end
    endtask

    task automatic test_reset_mid_stream();
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = i;
            lsu_valid = 1'b1; lsu_rd = 5'(25 + i); lsu_data = 32'hB0 + i;
            issue_valid = 1'b1; issue_rd = 5'(25 + i);
            step();
        end
        idle_inputs();
        reset = 1'b1;
        #2;
        clear_model();
        vectors++;
        if (busy_bits !== 32'd0 || write_params[0] !== 1'b0 || lsu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset: busy=%h we=%b ready=%b required 0/0/1", busy_bits, write_params[0], lsu_ready);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if (write_params[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_%0d: we=%b required 0", i, write_params[0]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            alu_valid   = $urandom_range(0, 2) == 0;
            alu_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu_data    = $urandom;
            lsu_valid   = $urandom_range(0, 1) == 1;
            lsu_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            lsu_data    = $urandom;
            issue_valid = $urandom_range(0, 2) == 0;
            issue_rd    = 5'($urandom_range(0, 31));
`ifdef WB_FORWARD_EN
            fwd_addr_rs1 = ($urandom_range(0, 1) == 1) ? m_addr : 5'($urandom_range(0, 31));
            fwd_addr_rs2 = 5'($urandom_range(0, 31));
            #1;
            vectors++;
            if (fwd_hit_rs1 !== (m_we && m_addr == fwd_addr_rs1 && m_addr != 0) ||
                fwd_hit_rs2 !== (m_we && m_addr == fwd_addr_rs2 && m_addr != 0) || fwd_data_rs1 !== m_data) begin
                miscompares++;
                $display("FAIL rnd_fwd_%0d: hit1=%b hit2=%b data=%h required addr=%0d we=%b data=%h",
                         i, fwd_hit_rs1, fwd_hit_rs2, fwd_data_rs1, m_addr, m_we, m_data);
            end
`endif
            vectors++;
            if (lsu_ready !== (q.size() < DEPTH)) begin
                miscompares++;
                $display("FAIL rnd_ready_%0d: lsu_ready=%b required %b", i, lsu_ready, q.size() < DEPTH);
            end
            step();
            vectors++;
            if (write_params !== {m_addr, m_we} || data_rd !== m_data) begin
                miscompares++;
                $display("FAIL rnd_write_%0d: write_params=%h data_rd=%h required %h/%h",
                         i, write_params, data_rd, {m_addr, m_we}, m_data);
            end
            vectors++;
            if (busy_bits !== m_busy) begin
                miscompares++;
                $display("FAIL rnd_busy_%0d: busy=%h required %h", i, busy_bits, m_busy);
            end
        end
        idle_inputs();
    endtask

    initial begin
        clear_model();
        test_reset();
        test_alu_write();
        test_alu_lsu_priority();
        test_fifo_full_drain();
        test_busy_set_wins();
        test_rd_zero();
        test_reset_mid_stream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
